// File: rtl/lexington_pkg.sv
// rtl/lexington_pkg.sv - shared LSU types; LEXINGTON_MISALIGNED_SPLIT_EN adds the ACCESS_HI state
package lexington_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_MISALIGNED = 2'd1,
    FAULT_ACCESS     = 2'd2
  } fault_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
`ifdef LEXINGTON_MISALIGNED_SPLIT_EN
    , ST_ACCESS_HI
`endif
  } lsu_state_t;

  // The undefined size encoding 2'b11 is handled as a word everywhere.
  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    case (size)
      MEM_BYTE: is_misaligned = 1'b0;
      MEM_HALF: is_misaligned = off[0];
      default:  is_misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic is_crossing(input mem_size_t size, input logic [1:0] off);
    case (size)
      MEM_BYTE: is_crossing = 1'b0;
      MEM_HALF: is_crossing = (off == 2'b11);
      default:  is_crossing = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/dbus_align.sv
// rtl/dbus_align.sv - byte-lane positioning for stores and extraction/extension for loads
module dbus_align import lexington_pkg::*; (
  input  mem_size_t       wr_size,
  input  logic [1:0]      wr_off,
  input  logic [XLEN-1:0] wr_wdata,
  output logic [7:0]      wr_strobe,
  output logic [63:0]     wr_data_sh,
  input  logic [63:0]     rd_raw,
  input  logic [1:0]      rd_off,
  input  mem_size_t       rd_size,
  input  logic            rd_unsigned,
  output logic [XLEN-1:0] rd_data_ext
);

  logic [7:0]      base_mask;
  logic [XLEN-1:0] raw_sh;
  logic            sgn;

  always_comb begin
    case (wr_size)
      MEM_BYTE: base_mask = 8'h01;
      MEM_HALF: base_mask = 8'h03;
      default:  base_mask = 8'h0f;
    endcase
    wr_strobe  = base_mask << wr_off;
    wr_data_sh = {32'b0, wr_wdata} << {wr_off, 3'b000};
  end

  always_comb begin
    raw_sh = XLEN'(rd_raw >> {rd_off, 3'b000});
    sgn    = 1'b0;
    case (rd_size)
      MEM_BYTE: begin
        sgn         = ~rd_unsigned & raw_sh[7];
        rd_data_ext = {{24{sgn}}, raw_sh[7:0]};
      end
      MEM_HALF: begin
        sgn         = ~rd_unsigned & raw_sh[15];
        rd_data_ext = {{16{sgn}}, raw_sh[15:0]};
      end
      default: rd_data_ext = raw_sh;
    endcase
  end

endmodule

// File: rtl/dbus_lsu.sv
// rtl/dbus_lsu.sv - DBus load/store initiator; LEXINGTON_MISALIGNED_SPLIT_EN performs misaligned accesses
module dbus_lsu import lexington_pkg::*; #(
  parameter int ADDR_WIDTH = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  mem_size_t             req_size,
  input  logic                  req_unsigned,
  input  logic [XLEN-1:0]       req_wdata,
  output logic                  resp_valid,
  output logic [XLEN-1:0]       resp_rdata,
  output fault_t                resp_fault,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [XLEN-1:0]       wr_data,
  output logic [XLEN/8-1:0]     wr_strobe,
  input  logic [XLEN-1:0]       rd_data,
  input  logic                  bus_err
);

  lsu_state_t            state_q, state_d;
  logic                  we_q, we_d;
  logic [1:0]            off_q, off_d;
  mem_size_t             size_q, size_d;
  logic                  uns_q, uns_d;
  logic [ADDR_WIDTH-1:0] word_q, word_d;
  logic                  rd_en_q, rd_en_d, wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic [XLEN/8-1:0]     wr_strobe_q, wr_strobe_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [XLEN-1:0]       resp_rdata_q, resp_rdata_d;
  fault_t                resp_fault_q, resp_fault_d;

  logic                  accept, req_mis;
  logic [7:0]            al_strobe;
  logic [63:0]           al_wdata, al_raw;
  logic [XLEN-1:0]       al_rdata;

`ifdef LEXINGTON_MISALIGNED_SPLIT_EN
  // Upper lanes of a crossing store are prepared at accept time and replayed in ACCESS_HI.
  logic [XLEN/8-1:0] strb_hi_q, strb_hi_d;
  logic [XLEN-1:0]   wdata_hi_q, wdata_hi_d, raw_lo_q, raw_lo_d;
  assign al_raw = (state_q == ST_ACCESS_HI) ? {rd_data, raw_lo_q} : {32'b0, rd_data};
`else
  logic unused_hi;
  assign unused_hi = ^{al_strobe[7:4], al_wdata[63:32]};
  assign al_raw    = {32'b0, rd_data};
`endif

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign req_mis   = is_misaligned(req_size, req_addr[1:0]);

  dbus_align u_align (
    .wr_size     (req_size),
    .wr_off      (req_addr[1:0]),
    .wr_wdata    (req_wdata),
    .wr_strobe   (al_strobe),
    .wr_data_sh  (al_wdata),
    .rd_raw      (al_raw),
    .rd_off      (off_q),
    .rd_size     (size_q),
    .rd_unsigned (uns_q),
    .rd_data_ext (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= MEM_BYTE;
      uns_q        <= 1'b0;
      word_q       <= '0;
      rd_en_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      wr_strobe_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= FAULT_NONE;
`ifdef LEXINGTON_MISALIGNED_SPLIT_EN
      strb_hi_q    <= '0;
      wdata_hi_q   <= '0;
      raw_lo_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      word_q       <= word_d;
      rd_en_q      <= rd_en_d;
      wr_en_q      <= wr_en_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      wr_strobe_q  <= wr_strobe_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_fault_q <= resp_fault_d;
`ifdef LEXINGTON_MISALIGNED_SPLIT_EN
      strb_hi_q    <= strb_hi_d;
      wdata_hi_q   <= wdata_hi_d;
      raw_lo_q     <= raw_lo_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
`ifdef LEXINGTON_MISALIGNED_SPLIT_EN
          state_d = ST_ACCESS;
`else
          state_d = req_mis ? ST_RESP : ST_ACCESS;
`endif
        end
      end
      ST_ACCESS: begin
`ifdef LEXINGTON_MISALIGNED_SPLIT_EN
        state_d = (is_crossing(size_q, off_q) && !bus_err) ? ST_ACCESS_HI : ST_RESP;
`else
        state_d = ST_RESP;
`endif
      end
`ifdef LEXINGTON_MISALIGNED_SPLIT_EN
      ST_ACCESS_HI: state_d = ST_RESP;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus and response outputs are registered: values computed here appear in the following state.
  always_comb begin
    we_d         = we_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    word_d       = word_q;
    rd_en_d      = 1'b0;
    wr_en_d      = 1'b0;
    addr_d       = '0;
    wr_data_d    = '0;
    wr_strobe_d  = '0;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_fault_d = FAULT_NONE;
`ifdef LEXINGTON_MISALIGNED_SPLIT_EN
    strb_hi_d    = strb_hi_q;
    wdata_hi_d   = wdata_hi_q;
    raw_lo_d     = raw_lo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          we_d   = req_we;
          off_d  = req_addr[1:0];
          size_d = req_size;
          uns_d  = req_unsigned;
          word_d = req_addr[ADDR_WIDTH+1:2];
          if (state_d == ST_ACCESS) begin
            rd_en_d = !req_we;
            wr_en_d = req_we;
            addr_d  = req_addr[ADDR_WIDTH+1:2];
            if (req_we) begin
              wr_strobe_d = al_strobe[3:0];
              wr_data_d   = al_wdata[31:0];
            end
`ifdef LEXINGTON_MISALIGNED_SPLIT_EN
            strb_hi_d  = req_we ? al_strobe[7:4] : '0;
            wdata_hi_d = req_we ? al_wdata[63:32] : '0;
`endif
          end else begin
            resp_valid_d = 1'b1;
            resp_fault_d = req_mis ? FAULT_MISALIGNED : FAULT_NONE;
          end
        end
      end
      ST_ACCESS: begin
`ifdef LEXINGTON_MISALIGNED_SPLIT_EN
        raw_lo_d = rd_data;
        if (state_d == ST_ACCESS_HI) begin
          rd_en_d     = !we_q;
          wr_en_d     = we_q;
          addr_d      = word_q + 1'b1;
          wr_strobe_d = strb_hi_q;
          wr_data_d   = wdata_hi_q;
        end else
`endif
        begin
          resp_valid_d = 1'b1;
          resp_fault_d = bus_err ? FAULT_ACCESS : FAULT_NONE;
          resp_rdata_d = (bus_err || we_q) ? '0 : al_rdata;
        end
      end
`ifdef LEXINGTON_MISALIGNED_SPLIT_EN
      ST_ACCESS_HI: begin
        resp_valid_d = 1'b1;
        resp_fault_d = bus_err ? FAULT_ACCESS : FAULT_NONE;
        resp_rdata_d = (bus_err || we_q) ? '0 : al_rdata;
      end
`endif
      default: ;
    endcase
  end

  assign rd_en      = rd_en_q;
  assign wr_en      = wr_en_q;
  assign addr       = addr_q;
  assign wr_data    = wr_data_q;
  assign wr_strobe  = wr_strobe_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_dbus_lsu.sv
// tb/tb_dbus_lsu.sv - scoreboard bench for dbus_lsu; expectations follow LEXINGTON_MISALIGNED_SPLIT_EN
module tb_dbus_lsu;
  import lexington_pkg::*;

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [29:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } bus_t;

  typedef struct {
    bus_t b;
    int   cyc;
  } bus_exp_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  fault;
    int          cyc;
  } resp_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  mem_size_t   req_size = MEM_BYTE;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  fault_t      resp_fault;
  logic        rd_en, wr_en;
  logic [29:0] addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strobe;
  logic [31:0] rd_data = '0;
  logic        bus_err = 1'b0;

  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  bus_exp_t  bus_q[$];
  resp_exp_t resp_q[$];

  always #5 clk = ~clk;

  dbus_lsu #(.ADDR_WIDTH(30)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .rd_en(rd_en), .wr_en(wr_en), .addr(addr), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .rd_data(rd_data), .bus_err(bus_err)
  );

  function automatic bus_t mk_bus(input logic rd, input logic wr, input logic [29:0] a,
                                  input logic [3:0] s, input logic [31:0] d);
    mk_bus = '{rd: rd, wr: wr, addr: a, strb: s, data: d};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Monitor: ncyc seen here is the index that a driver reading ncyc after the previous negedge predicts.
  always @(negedge clk) begin
    if (rd_en || wr_en) begin
      check("bus_rd_wr_exclusive", 64'(rd_en & wr_en), 64'd0);
      if (bus_q.size() == 0) begin
        check("bus_unexpected", 64'(1), 64'(0));
      end else begin
        bus_exp_t e;
        e = bus_q.pop_front();
        check("bus_fields", 64'({rd_en, wr_en, addr, wr_strobe, wr_data}), 64'(e.b));
        check("bus_cycle", 64'(ncyc), 64'(e.cyc));
      end
    end
    if (resp_valid) begin
      if (resp_q.size() == 0) begin
        check("resp_unexpected", 64'(1), 64'(0));
      end else begin
        resp_exp_t r;
        r = resp_q.pop_front();
        check("resp_rdata", 64'(resp_rdata), 64'(r.rdata));
        check("resp_fault", 64'(resp_fault), 64'(r.fault));
        check("resp_cycle", 64'(ncyc), 64'(r.cyc));
      end
    end
    ncyc <= ncyc + 1;
  end

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (req_ready) return;
    end
    check("wait_idle_timeout", 64'(0), 64'(1));
  endtask

  // lat: negedges from the first post-accept negedge (bus cycle) to resp, plus one.
  task automatic issue(input logic we, input logic [31:0] a, input mem_size_t sz, input logic uns,
                       input logic [31:0] wd, input logic [31:0] rdv, input logic berr,
                       input logic [31:0] exp_rd, input fault_t exp_f, input int lat,
                       input int nbus, input bus_t b0, input bus_t b1);
    int k;
    wait_idle();
    k = ncyc;
    req_we = we; req_addr = a; req_size = sz; req_unsigned = uns; req_wdata = wd;
    rd_data = rdv; bus_err = berr;
    if (nbus > 0) bus_q.push_back('{b: b0, cyc: k});
    if (nbus > 1) bus_q.push_back('{b: b1, cyc: k + 1});
    resp_q.push_back('{rdata: exp_rd, fault: exp_f, cyc: k + lat - 1});
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  initial begin
    bus_t nb;
    int   k;
    nb = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({rd_en, wr_en, resp_valid, addr, wr_data, wr_strobe, resp_rdata, resp_fault}), 64'(0));
    check("reset_ready_low", 64'(req_ready), 64'(0));
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'(1));

    issue(1'b0, 32'h10, MEM_WORD, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, FAULT_NONE, 2, 1,
          mk_bus(1, 0, 30'h4, 4'h0, 32'h0), nb);
    issue(1'b0, 32'h13, MEM_BYTE, 1'b0, 32'h0, 32'h80FF_0000, 1'b0, 32'hFFFF_FF80, FAULT_NONE, 2, 1,
          mk_bus(1, 0, 30'h4, 4'h0, 32'h0), nb);
    issue(1'b0, 32'h13, MEM_BYTE, 1'b1, 32'h0, 32'h80FF_0000, 1'b0, 32'h0000_0080, FAULT_NONE, 2, 1,
          mk_bus(1, 0, 30'h4, 4'h0, 32'h0), nb);
    issue(1'b0, 32'h12, MEM_HALF, 1'b0, 32'h0, 32'h80FF_0000, 1'b0, 32'hFFFF_80FF, FAULT_NONE, 2, 1,
          mk_bus(1, 0, 30'h4, 4'h0, 32'h0), nb);
    issue(1'b0, 32'h12, MEM_HALF, 1'b1, 32'h0, 32'h80FF_0000, 1'b0, 32'h0000_80FF, FAULT_NONE, 2, 1,
          mk_bus(1, 0, 30'h4, 4'h0, 32'h0), nb);
    issue(1'b0, 32'h01, MEM_BYTE, 1'b0, 32'h0, 32'h0000_7F00, 1'b0, 32'h0000_007F, FAULT_NONE, 2, 1,
          mk_bus(1, 0, 30'h0, 4'h0, 32'h0), nb);
    issue(1'b1, 32'h21, MEM_BYTE, 1'b0, 32'h0000_00AB, 32'hFFFF_FFFF, 1'b0, 32'h0, FAULT_NONE, 2, 1,
          mk_bus(0, 1, 30'h8, 4'b0010, 32'h0000_AB00), nb);
    issue(1'b1, 32'h02, MEM_HALF, 1'b0, 32'h0000_BEEF, 32'h0, 1'b0, 32'h0, FAULT_NONE, 2, 1,
          mk_bus(0, 1, 30'h0, 4'b1100, 32'hBEEF_0000), nb);
`ifdef LEXINGTON_MISALIGNED_SPLIT_EN
    issue(1'b1, 32'h22, MEM_WORD, 1'b0, 32'h1122_3344, 32'h0, 1'b0, 32'h0, FAULT_NONE, 3, 2,
          mk_bus(0, 1, 30'h8, 4'b1100, 32'h3344_0000), mk_bus(0, 1, 30'h9, 4'b0011, 32'h0000_1122));
    issue(1'b0, 32'h11, MEM_HALF, 1'b0, 32'h0, 32'h00AB_CD00, 1'b0, 32'hFFFF_ABCD, FAULT_NONE, 2, 1,
          mk_bus(1, 0, 30'h4, 4'h0, 32'h0), nb);
`else
    issue(1'b1, 32'h22, MEM_WORD, 1'b0, 32'h1122_3344, 32'h0, 1'b0, 32'h0, FAULT_MISALIGNED, 1, 0, nb, nb);
    issue(1'b0, 32'h11, MEM_HALF, 1'b0, 32'h0, 32'h00AB_CD00, 1'b0, 32'h0, FAULT_MISALIGNED, 1, 0, nb, nb);
`endif
    issue(1'b0, 32'h40, MEM_WORD, 1'b0, 32'h0, 32'h1234_5678, 1'b1, 32'h0, FAULT_ACCESS, 2, 1,
          mk_bus(1, 0, 30'h10, 4'h0, 32'h0), nb);
    issue(1'b1, 32'h30, MEM_WORD, 1'b0, 32'hA5A5_5A5A, 32'h0, 1'b1, 32'h0, FAULT_ACCESS, 2, 1,
          mk_bus(0, 1, 30'hC, 4'hF, 32'hA5A5_5A5A), nb);

    // Reset while the bus cycle is in flight.
    wait_idle();
    k = ncyc;
    req_we = 1'b0; req_addr = 32'h50; req_size = MEM_WORD; req_unsigned = 1'b0;
    rd_data = 32'h0BAD_F00D; bus_err = 1'b0;
    bus_q.push_back('{b: mk_bus(1, 0, 30'h14, 4'h0, 32'h0), cyc: k});
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_drops_bus", 64'({rd_en, wr_en, resp_valid}), 64'(0));
    check("rst_ready_low", 64'(req_ready), 64'(0));
    #1 rst = 1'b0;
    @(negedge clk);
    check("ready_after_midop_rst", 64'(req_ready), 64'(1));

    // Held req_valid: accepted once every three cycles.
    wait_idle();
    k = ncyc;
    req_we = 1'b0; req_addr = 32'h60; req_size = MEM_WORD; req_unsigned = 1'b0;
    rd_data = 32'hCAFE_F00D; bus_err = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_q.push_back('{b: mk_bus(1, 0, 30'h18, 4'h0, 32'h0), cyc: k + 3 * i});
      resp_q.push_back('{rdata: 32'hCAFE_F00D, fault: FAULT_NONE, cyc: k + 3 * i + 1});
    end
    req_valid = 1'b1;
    repeat (7) @(posedge clk);
    #1 req_valid = 1'b0;

    repeat (6) @(negedge clk);
    check("bus_queue_drained", 64'(bus_q.size()), 64'(0));
    check("resp_queue_drained", 64'(resp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
